// File: rtl/mat_mac_engine.sv
// 3x3 unsigned matrix multiplier, result = A x B, built around one MAC unit.
// Each result element takes three accumulate cycles plus one store cycle.
module mat_mac_engine #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_trigger,
  input  logic [9*WIDTH-1:0] i_a,
  input  logic [9*WIDTH-1:0] i_b,
  output logic [9*WIDTH-1:0] o_result,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    STORE
  } state_t;

  state_t state, state_nxt;

  logic               trig_q;
  logic               start;
  logic [9*WIDTH-1:0] a_r, b_r;
  logic [1:0]         row, col, k;
  logic [ACC_W-1:0]   acc;
  logic [3:0]         a_idx, b_idx, r_idx;
  logic [WIDTH-1:0]   a_el, b_el;
  logic [ACC_W-1:0]   prod;
  logic               last_el;

  assign start   = i_trigger & ~trig_q;
  assign a_idx   = 4'(row) * 4'd3 + 4'(k);
  assign b_idx   = 4'(k) * 4'd3 + 4'(col);
  assign r_idx   = 4'(row) * 4'd3 + 4'(col);
  assign a_el    = a_r[32'(a_idx)*WIDTH +: WIDTH];
  assign b_el    = b_r[32'(b_idx)*WIDTH +: WIDTH];
  assign prod    = ACC_W'(a_el) * ACC_W'(b_el);
  assign last_el = (row == 2'd2) && (col == 2'd2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (k == 2'd2) state_nxt = STORE;
      STORE:   state_nxt = last_el ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trig_q     <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      row        <= '0;
      col        <= '0;
      k          <= '0;
      acc        <= '0;
      o_result   <= '0;
      o_ready    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      trig_q <= i_trigger;
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_r        <= i_a;
            b_r        <= i_b;
            row        <= '0;
            col        <= '0;
            k          <= '0;
            acc        <= '0;
            o_ready    <= 1'b0;
            o_overflow <= 1'b0;
            o_busy     <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + prod;
          k   <= (k == 2'd2) ? 2'd0 : k + 2'd1;
        end
        STORE: begin
          o_result[32'(r_idx)*WIDTH +: WIDTH] <= acc[WIDTH-1:0];
          // any bit above the element width means truncation lost data
          if (|acc[ACC_W-1:WIDTH]) o_overflow <= 1'b1;
          acc <= '0;
          k   <= '0;
          if (col == 2'd2) begin
            col <= '0;
            row <= (row == 2'd2) ? 2'd0 : row + 2'd1;
          end else begin
            col <= col + 2'd1;
          end
          if (last_el) begin
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
            o_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mac_engine.sv
// Randomised scoreboard bench for mat_mac_engine.
// A reference matrix product is queued per run and checked on each done pulse.
module tb_mat_mac_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trigger;
  logic [71:0] ia, ib;
  logic [71:0] o_result;
  logic        o_ready, o_busy, o_done, o_overflow;

  typedef struct {
    logic [71:0] r;
    logic        ov;
    int          c;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   base = 0;
  bit   ready_exp = 1'b0;
  bit   prev_done = 1'b0;

  mat_mac_engine #(.WIDTH(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_trigger  (trigger),
    .i_a        (ia),
    .i_b        (ib),
    .o_result   (o_result),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void matmul(input logic [71:0] a, input logic [71:0] b,
                                 output logic [71:0] r, output logic ov);
    int unsigned s;
    r  = '0;
    ov = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int m = 0; m < 3; m++)
          s += int'(a[(3*i+m)*8 +: 8]) * int'(b[(3*m+j)*8 +: 8]);
        r[(3*i+j)*8 +: 8] = s[7:0];
        if (s > 255) ov = 1'b1;
      end
  endfunction

  function automatic logic [71:0] pack9(input int v[9]);
    logic [71:0] p;
    for (int i = 0; i < 9; i++) p[i*8 +: 8] = v[i][7:0];
    return p;
  endfunction

  function automatic logic [71:0] splat(input logic [7:0] x);
    logic [71:0] p;
    for (int i = 0; i < 9; i++) p[i*8 +: 8] = x;
    return p;
  endfunction

  task automatic start_run(input logic [71:0] a, input logic [71:0] b,
                           input bit hold);
    logic [71:0] r;
    logic        ov;
    exp_t        e;
    @(negedge clk);
    trigger = 1'b0;
    check(o_ready == ready_exp, "ready_before_start", 72'(o_ready), 72'(ready_exp));
    @(negedge clk);
    ia = a;
    ib = b;
    trigger = 1'b1;
    matmul(a, b, r, ov);
    base = done_cnt;
    @(posedge clk);
    #1;
    e.r  = r;
    e.ov = ov;
    e.c  = cyc;
    sb.push_back(e);
    check(o_busy == 1'b1, "busy_on_start", 72'(o_busy), 72'd1);
    check(o_ready == 1'b0, "ready_drop_on_start", 72'(o_ready), 72'd0);
    if (!hold) begin
      @(negedge clk);
      trigger = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80 && done_cnt == base; i++) @(posedge clk);
    #2;
    check(done_cnt != base, "done_timeout", 72'(done_cnt), 72'(base + 1));
  endtask

  // monitor: pops the scoreboard on every completion pulse
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_done = 1'b0;
        continue;
      end
      if (prev_done)
        check(o_done == 1'b0, "done_one_cycle", 72'(o_done), 72'd0);
      if (o_done) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_done", 72'(o_done), 72'd0);
        end else begin
          e = sb.pop_front();
          check(o_result == e.r, "result", o_result, e.r);
          check(o_overflow == e.ov, "overflow", 72'(o_overflow), 72'(e.ov));
          check(o_ready && !o_busy, "ready_busy_at_done",
                72'({o_ready, o_busy}), 72'b10);
          check(cyc - e.c == 36, "latency", 72'(cyc - e.c), 72'd36);
        end
        ready_exp = 1'b1;
        done_cnt++;
      end
      prev_done = o_done;
    end
  end

  initial begin
    int va[9], vb[9];
    logic [71:0] ident, exp_v;

    rst_n   = 1'b0;
    trigger = 1'b0;
    ia      = '0;
    ib      = '0;
    repeat (3) @(posedge clk);
    #1;
    check(o_result == '0, "reset_result", o_result, '0);
    check({o_ready, o_busy, o_done, o_overflow} == 4'b0, "reset_flags",
          72'({o_ready, o_busy, o_done, o_overflow}), '0);
    @(negedge clk);
    rst_n = 1'b1;

    va = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    vb = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    start_run(pack9(va), pack9(vb), 1'b0);
    wait_done();
    va = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    exp_v = pack9(va);
    check(o_result == exp_v, "known_product", o_result, exp_v);

    va = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    ident = pack9(va);
    vb = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
    start_run(ident, pack9(vb), 1'b0);
    wait_done();
    start_run(splat(8'd2), splat(8'd2), 1'b0);
    wait_done();
    exp_v = splat(8'd12);
    check(o_result == exp_v, "all_twos", o_result, exp_v);

    start_run(splat(8'd255), splat(8'd255), 1'b0);
    wait_done();
    exp_v = splat(8'd3);
    check(o_result == exp_v, "all_255", o_result, exp_v);
    check(o_overflow == 1'b1, "ovf_255", 72'(o_overflow), 72'd1);
    start_run(ident, ident, 1'b0);
    wait_done();
    check(o_overflow == 1'b0, "ovf_cleared", 72'(o_overflow), 72'd0);

    // level held high must produce only one run
    start_run(pack9(vb), ident, 1'b1);
    repeat (100) @(posedge clk);
    #2;
    check(done_cnt == base + 1, "hold_single_run", 72'(done_cnt), 72'(base + 1));
    @(negedge clk);
    trigger = 1'b0;

    // second rise while busy is ignored
    start_run({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 1'b0);
    repeat (8) @(negedge clk);
    trigger = 1'b1;
    repeat (3) @(negedge clk);
    trigger = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    check(done_cnt == base + 1, "retrigger_ignored", 72'(done_cnt), 72'(base + 1));

    // operands are captured at the start edge
    start_run({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 1'b0);
    repeat (4) @(negedge clk);
    ia = {$urandom, $urandom, $urandom};
    ib = {$urandom, $urandom, $urandom};
    wait_done();

    // asynchronous reset mid-run
    start_run(splat(8'd7), splat(8'd9), 1'b0);
    repeat (19) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(o_result == '0, "midrun_reset_result", o_result, '0);
    check({o_ready, o_busy, o_done, o_overflow} == 4'b0, "midrun_reset_flags",
          72'({o_ready, o_busy, o_done, o_overflow}), '0);
    sb.delete();
    ready_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_run(pack9(vb), pack9(vb), 1'b0);
    wait_done();

    for (int n = 0; n < 10; n++) begin
      logic [71:0] ra, rb;
      for (int i = 0; i < 9; i++) begin
        ra[i*8 +: 8] = (n % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        rb[i*8 +: 8] = (n % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      end
      start_run(ra, rb, 1'b0);
      wait_done();
    end

    repeat (5) @(posedge clk);
    #2;
    check(sb.size() == 0, "scoreboard_drained", 72'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mat_mac_engine.md
Name: mat_mac_engine

Overview:
Sequential 3x3 matrix multiplier: result = A x B, with 8-bit elements, using a single multiply-accumulate unit. It sits between the matrix-load logic, which captures A and B from the UART receive buffer, and the transmit buffer, which serialises the result back out over UART. Operands are captured on a rising edge of the trigger. The result is held stable and flagged ready until the next run starts.

Parameters:
WIDTH, 8, bits per matrix element (operands and result)
ACC_W, 2*WIDTH+2, accumulator width; holds the full sum of 3 products without loss

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_trigger  input  1  start request; level signal, only its rising edge starts a run
i_a  input  9*WIDTH  matrix A, row-major; element (r,c) at bits [(3r+c)*WIDTH +: WIDTH]
i_b  input  9*WIDTH  matrix B, same packing as i_a
o_result  output  9*WIDTH  A x B, same packing; each element truncated to WIDTH bits
o_ready  output  1  high while o_result holds a completed product
o_busy  output  1  high while a computation is in progress
o_done  output  1  one-cycle pulse on completion
o_overflow  output  1  high if any result element exceeded 2^WIDTH-1 in the last run

Behaviour:
- Reset (async, i_rst_n=0):
  - o_result=0, o_ready=0, o_busy=0, o_done=0, o_overflow=0.
  - Trigger edge-detect register cleared to 0. State=IDLE.
  - All counters and the accumulator cleared.
- Edge detect: trig_q registers i_trigger every cycle, including while busy. start = i_trigger & ~trig_q.
- States: IDLE, MAC, STORE.
- IDLE, on start:
  - Latch i_a and i_b into internal registers; later input changes have no effect on the run.
  - Clear row/col/k counters and the accumulator.
  - o_ready<=0, o_overflow<=0, o_busy<=1. Go to MAC.
- MAC:
  - acc <= acc + a[row][k] * b[k][col], unsigned.
  - k counts 0..2; after the k=2 edge, go to STORE.
- STORE:
  - Write acc[WIDTH-1:0] to result element (row,col).
  - If acc > 2^WIDTH-1, set o_overflow (sticky for the rest of the run).
  - Clear acc and k. Advance col 0..2, wrapping into row 0..2.
  - After element (2,2): o_busy<=0, o_ready<=1, o_done<=1 for one cycle. Go to IDLE.
  - Otherwise go to MAC.
- Latency: 9 elements x (3 MAC + 1 STORE) = 36 cycles. o_ready and o_done are high after the 36th rising edge following the capture edge.
- o_result updates element by element during a run. Consumers use it only while o_ready=1.
- A trigger rise while busy is ignored and is not queued. A level held high after completion does not restart the block; a new run needs i_trigger to go low, then high.
- o_ready stays high indefinitely until the next start or reset.
- Reset mid-run: abort immediately to reset values. No partial result is flagged ready.
- Arithmetic: products are 2*WIDTH bits and the accumulator is ACC_W bits, so no intermediate wrap occurs. Only the final truncation to WIDTH bits can lose data, and o_overflow reports it.

Test Plan:
- A=[1..9] row-major, B=[9..1] row-major, pulse trigger -> o_result=[30,24,18,84,69,54,138,114,90]; o_ready rises exactly 36 cycles after the capture edge; o_done high for 1 cycle; o_overflow=0.
- A=identity, B=[10,20,...,90] -> o_result=B. Then A=all 2s, B=all 2s -> every element 12; o_ready drops on the start edge and rises again 36 cycles later.
- A=B=all 255 -> every element 195075 mod 256 = 3; o_overflow=1. Next run with identity x identity -> o_overflow=0, result=identity.
- Hold i_trigger high for 100 cycles -> exactly one run and one o_done pulse. Raise i_trigger again at cycle 10 of a fresh run (after a low period) -> ignored; still a single o_done at cycle 36.
- Change i_a and i_b at cycle 5 of a run -> result matches the operands captured at the start edge.
- Assert i_rst_n=0 at cycle 20 of a run -> all outputs 0 immediately, with no clock edge needed. After release, a new trigger produces a correct result in 36 cycles.
